// File: rtl/move_enable_gate_if.sv
// rtl/move_enable_gate_if.sv - move request/outcome handshake bundle
//
// Purpose: groups the player move request handshake and the resulting
// grant/reject outcome into one bundle shared by the requester and the gate.
//
// Signals:
//   req_valid   requester -> gate  move request valid
//   req_dir     requester -> gate  requested direction (0 up, 1 down, 2 left, 3 right)
//   req_ready   gate -> requester  request accepted when req_valid & req_ready
//   move_grant  gate -> requester  one-cycle pulse, move permitted
//   move_reject gate -> requester  one-cycle pulse, move refused
//   move_dir    gate -> requester  direction of the current grant/reject
//
// Modports: master = requester side, slave = gate side.

interface move_enable_gate_if;
  logic       req_valid;
  logic [1:0] req_dir;
  logic       req_ready;
  logic       move_grant;
  logic       move_reject;
  logic [1:0] move_dir;

  modport master (
    output req_valid,
    output req_dir,
    input  req_ready,
    input  move_grant,
    input  move_reject,
    input  move_dir
  );

  modport slave (
    input  req_valid,
    input  req_dir,
    output req_ready,
    output move_grant,
    output move_reject,
    output move_dir
  );
endinterface

// File: rtl/move_enable_gate.sv
// rtl/move_enable_gate.sv - per-cell direction-enable reducer and move request arbiter
//
// Purpose: reduces per-cell up/down/left/right enable flags over a ROWS x COLS
// piece grid into registered per-direction "move allowed" bits (only cells
// marked occupied by cell_mask take part), then arbitrates move requests:
// each accepted request yields exactly one grant or reject pulse, and a grant
// is followed by a hold-off window during which requests are dropped.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-high
//   bus         move_enable_gate_if.slave: req_valid/req_dir/req_ready,
//               move_grant/move_reject/move_dir
//   cell_mask   ROWS*COLS, 1 = cell occupied and must permit the move
//   up_en       ROWS*COLS per-cell up enable
//   down_en     ROWS*COLS per-cell down enable
//   left_en     ROWS*COLS per-cell left enable
//   right_en    ROWS*COLS per-cell right enable
//   dir_ok      registered per-direction allowed bits {right,left,down,up}
//   grant_cnt   total grants issued (wraps)
//   reject_cnt  total rejects issued (wraps)
//
// Flag layout: bit index = r + ROWS*c (r = row, c = column).

module move_enable_gate #(
  parameter int ROWS           = 4,
  parameter int COLS           = 6,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  move_enable_gate_if.slave      bus,
  input  logic [ROWS*COLS-1:0]   cell_mask,
  input  logic [ROWS*COLS-1:0]   up_en,
  input  logic [ROWS*COLS-1:0]   down_en,
  input  logic [ROWS*COLS-1:0]   left_en,
  input  logic [ROWS*COLS-1:0]   right_en,
  output logic [3:0]             dir_ok,
  output logic [CNT_W-1:0]       grant_cnt,
  output logic [CNT_W-1:0]       reject_cnt
);

  // Hold-off counter only has to represent HOLDOFF_CYCLES-1 down to 0.
  localparam int HOLD_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    GRANT,
    REJECT,
    HOLDOFF
  } gateState_e;

  gateState_e        state, stateNext;
  logic [3:0]        dirOkQ, dirOkNext;
  logic [1:0]        moveDirQ, moveDirNext;
  logic              grantQ, grantNext;
  logic              rejectQ, rejectNext;
  logic [CNT_W-1:0]  grantCntQ, grantCntNext;
  logic [CNT_W-1:0]  rejectCntQ, rejectCntNext;
  logic [HOLD_W-1:0] holdCntQ, holdCntNext;

  // A direction is allowed when every occupied cell enables it; unoccupied
  // cells are forced to "allow", so an empty mask permits every direction.
  always_comb begin
    dirOkNext[0] = &(up_en    | ~cell_mask);
    dirOkNext[1] = &(down_en  | ~cell_mask);
    dirOkNext[2] = &(left_en  | ~cell_mask);
    dirOkNext[3] = &(right_en | ~cell_mask);
  end

  // Next-state and next-output decode. The EVAL decision reads dirOkQ, which
  // was captured at the acceptance edge, so flag changes after acceptance
  // cannot influence the outcome.
  always_comb begin
    stateNext     = state;
    moveDirNext   = moveDirQ;
    grantNext     = 1'b0;
    rejectNext    = 1'b0;
    grantCntNext  = grantCntQ;
    rejectCntNext = rejectCntQ;
    holdCntNext   = holdCntQ;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          moveDirNext = bus.req_dir;
          stateNext   = EVAL;
        end
      end

      EVAL: begin
        if (dirOkQ[moveDirQ]) begin
          stateNext = GRANT;
        end else begin
          stateNext = REJECT;
        end
      end

      GRANT: begin
        grantNext    = 1'b1;
        grantCntNext = grantCntQ + CNT_W'(1);
        if (HOLDOFF_CYCLES == 0) begin
          stateNext = IDLE;
        end else begin
          stateNext   = HOLDOFF;
          holdCntNext = HOLD_W'(HOLD_LOAD);
        end
      end

      REJECT: begin
        rejectNext    = 1'b1;
        rejectCntNext = rejectCntQ + CNT_W'(1);
        stateNext     = IDLE;
      end

      HOLDOFF: begin
        // Requests arriving here are dropped; ready stays low until IDLE.
        if (holdCntQ == '0) begin
          stateNext = IDLE;
        end else begin
          holdCntNext = holdCntQ - HOLD_W'(1);
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Grant/reject pulses are registered one edge after the GRANT/REJECT state
  // is entered; an asynchronous reset in between discards them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dirOkQ     <= 4'b0000;
      moveDirQ   <= 2'd0;
      grantQ     <= 1'b0;
      rejectQ    <= 1'b0;
      grantCntQ  <= '0;
      rejectCntQ <= '0;
      holdCntQ   <= '0;
    end else begin
      state      <= stateNext;
      dirOkQ     <= dirOkNext;
      moveDirQ   <= moveDirNext;
      grantQ     <= grantNext;
      rejectQ    <= rejectNext;
      grantCntQ  <= grantCntNext;
      rejectCntQ <= rejectCntNext;
      holdCntQ   <= holdCntNext;
    end
  end

  // Ready depends on state only, never on req_valid.
  assign bus.req_ready   = (state == IDLE);
  assign bus.move_grant  = grantQ;
  assign bus.move_reject = rejectQ;
  assign bus.move_dir    = moveDirQ;
  assign dir_ok          = dirOkQ;
  assign grant_cnt       = grantCntQ;
  assign reject_cnt      = rejectCntQ;

endmodule

// File: tb/tb_move_enable_gate.sv
// tb/tb_move_enable_gate.sv - randomized self-checking bench for move_enable_gate

module tb_move_enable_gate;
  localparam int ROWS = 4;
  localparam int COLS = 6;
  localparam int NC   = ROWS * COLS;
  localparam int HOLD = 3;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  move_enable_gate_if bus ();

  logic [NC-1:0] cellMask, upEn, downEn, leftEn, rightEn;
  logic [3:0]    dirOk;
  logic [CW-1:0] grantCnt, rejectCnt;

  move_enable_gate #(
    .ROWS(ROWS), .COLS(COLS), .HOLDOFF_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cell_mask  (cellMask),
    .up_en      (upEn),
    .down_en    (downEn),
    .left_en    (leftEn),
    .right_en   (rightEn),
    .dir_ok     (dirOk),
    .grant_cnt  (grantCnt),
    .reject_cnt (rejectCnt)
  );

  int compCnt = 0;
  int errCnt  = 0;
  int cyc     = 0;

  // Transaction-level reference state.
  int         readyFrom;   // first cycle in which the gate is ready again
  int         pulseCyc;    // cycle in which the pending outcome pulse is visible
  bit         pulseGrant;
  int         expGrants;
  int         expRejects;
  logic [1:0] expDir;
  logic [3:0] expDirOk;

  localparam logic [NC-1:0] ALL1 = '1;
  localparam logic [NC-1:0] ALL0 = '0;

  task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // A direction is legal when no occupied cell forbids it.
  function automatic bit cellsAllow(input logic [1:0] d, input logic [NC-1:0] m,
                                    input logic [NC-1:0] u, input logic [NC-1:0] dn,
                                    input logic [NC-1:0] l, input logic [NC-1:0] r);
    logic [NC-1:0] en;
    case (d)
      2'd0:    en = u;
      2'd1:    en = dn;
      2'd2:    en = l;
      default: en = r;
    endcase
    for (int i = 0; i < NC; i++) begin
      if (m[i] && !en[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutputs();
    expectEq("req_ready",   bus.req_ready,   32'(cyc >= readyFrom));
    expectEq("move_grant",  bus.move_grant,  32'(cyc == pulseCyc && pulseGrant));
    expectEq("move_reject", bus.move_reject, 32'(cyc == pulseCyc && !pulseGrant));
    expectEq("move_dir",    bus.move_dir,    expDir);
    expectEq("dir_ok",      dirOk,           expDirOk);
    expectEq("grant_cnt",   grantCnt,        expGrants % (1 << CW));
    expectEq("reject_cnt",  rejectCnt,       expRejects % (1 << CW));
  endtask

  task automatic modelReset();
    readyFrom  = 0;
    pulseCyc   = -1;
    pulseGrant = 1'b0;
    expGrants  = 0;
    expRejects = 0;
    expDir     = 2'd0;
    expDirOk   = 4'b0000;
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic step(input bit v, input logic [1:0] d, input logic [NC-1:0] m,
                      input logic [NC-1:0] u, input logic [NC-1:0] dn,
                      input logic [NC-1:0] l, input logic [NC-1:0] r);
    bit acc, ok;
    bus.req_valid = v;
    bus.req_dir   = d;
    cellMask = m; upEn = u; downEn = dn; leftEn = l; rightEn = r;
    acc = v && (cyc >= readyFrom);
    ok  = cellsAllow(d, m, u, dn, l, r);
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 4; k++) expDirOk[k] = cellsAllow(2'(k), m, u, dn, l, r);
    if (cyc == pulseCyc) begin
      if (pulseGrant) expGrants++;
      else            expRejects++;
    end
    if (acc) begin
      expDir     = d;
      pulseCyc   = cyc + 2;
      pulseGrant = ok;
      readyFrom  = cyc + 2 + (ok ? HOLD : 0);
    end
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, ALL1, ALL1, ALL1, ALL1, ALL1);
  endtask

  // Asynchronous reset pulse asserted mid-cycle, away from the clock edge.
  task automatic resetMid();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutputs();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    checkOutputs();
  endtask

  function automatic logic [NC-1:0] randEn();
    logic [NC-1:0] e;
    e = '1;
    if ($urandom_range(0, 2) == 0) e[$urandom_range(0, NC - 1)] = 1'b0;
    if ($urandom_range(0, 7) == 0) e[$urandom_range(0, NC - 1)] = 1'b0;
    return e;
  endfunction

  initial begin
    logic [NC-1:0] dnHole, maskHole, m;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_dir   = 2'd0;
    cellMask = '0; upEn = '0; downEn = '0; leftEn = '0; rightEn = '0;
    modelReset();
    @(negedge clk);
    checkOutputs();
    @(posedge clk);
    @(negedge clk);
    checkOutputs();
    rst = 1'b0;

    // All enables set, full mask, request down -> grant, then hold-off.
    step(1'b1, 2'd1, ALL1, ALL1, ALL1, ALL1, ALL1);
    idle(7);

    // One occupied cell forbids down -> reject; then unoccupy it -> grant.
    dnHole = ALL1;
    dnHole[13] = 1'b0;
    step(1'b1, 2'd1, ALL1, ALL1, dnHole, ALL1, ALL1);
    idle(4);
    maskHole = ALL1;
    maskHole[13] = 1'b0;
    step(1'b1, 2'd1, maskHole, ALL1, dnHole, ALL1, ALL1);
    idle(2);

    // Request held valid through the hold-off window.
    for (int i = 0; i < 10; i++) step(1'b1, 2'd3, ALL1, ALL1, ALL1, ALL1, ALL1);
    idle(8);

    // Left flags drop right after acceptance -> decision uses captured flags.
    step(1'b1, 2'd2, ALL1, ALL1, ALL1, ALL1, ALL1);
    step(1'b0, 2'd0, ALL1, ALL1, ALL1, ALL0, ALL1);
    step(1'b0, 2'd0, ALL1, ALL1, ALL1, ALL0, ALL1);
    idle(6);

    // Empty mask with every enable clear -> all directions allowed.
    step(1'b1, 2'd0, ALL0, ALL0, ALL0, ALL0, ALL0);
    idle(6);

    // Grants back to back until the narrow counter wraps.
    for (int g = 0; g < 5; g++) begin
      step(1'b1, 2'($urandom_range(0, 3)), ALL1, ALL1, ALL1, ALL1, ALL1);
      idle(6);
    end

    // Reset during EVAL aborts the pending outcome.
    step(1'b1, 2'd1, ALL1, ALL1, ALL1, ALL1, ALL1);
    resetMid();
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      m = ($urandom_range(0, 3) == 0) ? ALL0 : NC'($urandom);
      step(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
           m, randEn(), randEn(), randEn(), randEn());
      if ($urandom_range(0, 299) == 0) resetMid();
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/move_enable_gate.md
Name: move_enable_gate

Overview:
- Parametrised, registered successor to the fixed 4x6 per-cell direction-enable combiner.
- Reduces per-cell up/down/left/right enable flags across a ROWS x COLS piece grid into per-direction "move allowed" bits. Only cells marked occupied by a mask are considered.
- Arbitrates player move requests through a valid/ready handshake, issues one-cycle grant or reject pulses, and enforces a hold-off window after each grant.
- Sits between input debounce logic and the piece-position update logic.

Parameters:
- ROWS, 4, grid rows per piece window.
- COLS, 6, grid columns (scroll positions).
- HOLDOFF_CYCLES, 16, cycles in which requests are blocked after a grant; 0 disables hold-off.
- CNT_W, 8, width of the grant and reject counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cell_mask  in  ROWS*COLS  1 = cell occupied and must permit the move.
- up_en  in  ROWS*COLS  per-cell up enable.
- down_en  in  ROWS*COLS  per-cell down enable.
- left_en  in  ROWS*COLS  per-cell left enable.
- right_en  in  ROWS*COLS  per-cell right enable.
- req_valid  in  1  move request valid.
- req_dir  in  2  requested direction: 0 up, 1 down, 2 left, 3 right.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- move_grant  out  1  one-cycle pulse; move permitted.
- move_reject  out  1  one-cycle pulse; move refused.
- move_dir  out  2  direction of the current grant or reject.
- dir_ok  out  4  registered per-direction allowed bits {right,left,down,up}.
- grant_cnt  out  CNT_W  total grants issued.
- reject_cnt  out  CNT_W  total rejects issued.

Behaviour:
- Flag layout: bit index = r + ROWS*c, with r = row and c = column.
- Reduction: dir_ok[d] <= AND over all i of (en_d[i] | ~cell_mask[i]). The register updates every clock, so latency is 1 cycle.
  - An all-zero mask yields dir_ok = 4'b1111.
- Reset (async, rst=1):
  - State = IDLE.
  - dir_ok = 0, move_grant = 0, move_reject = 0, move_dir = 0.
  - grant_cnt = 0, reject_cnt = 0, hold-off counter = 0.
  - req_ready = 1 while in reset (IDLE).
  - Reset asserted mid-operation aborts any pending grant or reject; no pulse is emitted.
- FSM states: IDLE, EVAL, GRANT, REJECT, HOLDOFF.
  - IDLE:
    - req_ready = 1.
    - On req_valid: latch req_dir into move_dir, go to EVAL.
    - The enable flags present in this acceptance cycle are the ones registered into dir_ok.
  - EVAL:
    - req_ready = 0.
    - If dir_ok[move_dir] = 1, go to GRANT; otherwise go to REJECT.
    - Flag changes after the acceptance cycle do not affect the decision.
  - GRANT:
    - move_grant = 1 for exactly one cycle; grant_cnt increments.
    - Go to HOLDOFF with counter = HOLDOFF_CYCLES-1.
    - If HOLDOFF_CYCLES = 0, go to IDLE instead.
  - REJECT:
    - move_reject = 1 for exactly one cycle; reject_cnt increments.
    - Go to IDLE; no hold-off applies after a reject.
  - HOLDOFF:
    - req_ready = 0; requests are dropped, not queued.
    - Counter decrements each cycle; when counter = 0, go to IDLE.
- Latency: request accepted at edge N; grant or reject is high in the cycle following edge N+2.
- Throughput:
  - After a reject, a new request can be accepted 3 cycles after the previous one.
  - After a grant, the next request can be accepted no sooner than 3 + HOLDOFF_CYCLES cycles.
- move_grant and move_reject are never high together. Both are registered outputs.
- move_dir holds its value until the next acceptance.
- Counters wrap modulo 2^CNT_W.
- req_ready is decoded combinationally from state only; it has no combinational path from req_valid.
- req_dir is don't-care when req_valid = 0.

Test Plan:
- Reset with ROWS=4, COLS=6, HOLDOFF_CYCLES=3: all outputs zero, req_ready=1. Assert rst during EVAL -> no grant pulse; state IDLE.
- All enables 1, mask 24'hFFFFFF, request dir=1 (down) at edge N -> move_grant=1, move_dir=1 in the cycle after edge N+2; grant_cnt=1; req_ready low for 5 cycles after acceptance.
- down_en bit 13 = 0, mask bit 13 = 1, request down -> move_reject=1, reject_cnt=1, req_ready high 3 cycles after acceptance. Repeat with mask bit 13 = 0 -> move_grant=1.
- Issue a request during HOLDOFF -> ignored: no extra grant, grant_cnt unchanged. The request held until IDLE is then accepted.
- Toggle left_en to all-zero in the cycle after acceptance of a left request (flags were OK in the acceptance cycle) -> grant still issued. dir_ok[2] reads 0 on the following cycle.
- CNT_W=2, five grants -> grant_cnt=1 (wraps). Mask all-zero with enables all zero -> dir_ok=4'b1111 and grant issued.
